// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Single-outstanding APB master: turns a valid/ready command into one APB
// SETUP/ACCESS transfer and reports completion as a one-cycle response pulse.
// Every output comes straight from a flop.
// Build option: define APB_BRIDGE_TIMEOUT_EN to add a watchdog that aborts
// an ACCESS phase after TIMEOUT_CYCLES stalled edges. Without it, ACCESS
// waits for PREADY indefinitely.
module apb_master_bridge #(
   parameter int PDATA_SIZE     = 32,
   parameter int PADDR_SIZE     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      PCLK,
   input  logic                      PRESETn,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [PADDR_SIZE-1:0]     cmd_addr,
   input  logic [PDATA_SIZE/8-1:0]   cmd_strb,
   input  logic [PDATA_SIZE-1:0]     cmd_wdata,
   output logic                      rsp_valid,
   output logic [PDATA_SIZE-1:0]     rsp_rdata,
   output logic                      rsp_err,
   output logic                      PSEL,
   output logic                      PENABLE,
   output logic [PADDR_SIZE-1:0]     PADDR,
   output logic                      PWRITE,
   output logic [PDATA_SIZE/8-1:0]   PSTRB,
   output logic [PDATA_SIZE-1:0]     PWDATA,
   input  logic [PDATA_SIZE-1:0]     PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   localparam int STRB_W = PDATA_SIZE / 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   logic [1:0]            r_state;
   logic                  r_cmd_ready;
   logic                  r_psel;
   logic                  r_penable;
   logic [PADDR_SIZE-1:0] r_paddr;
   logic                  r_pwrite;
   logic [STRB_W-1:0]     r_pstrb;
   logic [PDATA_SIZE-1:0] r_pwdata;
   logic                  r_rsp_valid;
   logic [PDATA_SIZE-1:0] r_rsp_rdata;
   logic                  r_rsp_err;

   logic                  w_accept;
   logic                  w_done;
   logic                  w_timeout;

   assign w_accept = (r_state == ST_IDLE) && cmd_valid;
   assign w_done   = (r_state == ST_ACCESS) && PREADY;

`ifdef APB_BRIDGE_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   logic [7:0] r_wait_cnt;

   // Count stalled ACCESS edges; the SETUP edge clears it on the way into ACCESS.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_wait_cnt <= '0;
      end else if (r_state == ST_SETUP) begin
         r_wait_cnt <= '0;
      end else if ((r_state == ST_ACCESS) && !PREADY) begin
         r_wait_cnt <= r_wait_cnt + 8'd1;
      end
   end

   // PREADY on the limit edge still counts as a normal completion.
   assign w_timeout = (r_state == ST_ACCESS) && !PREADY && (r_wait_cnt == TIMEOUT_LIMIT);
`else
   assign w_timeout = 1'b0;
`endif

   // Transfer sequencer: walks IDLE -> SETUP -> ACCESS and drives PSEL/PENABLE/cmd_ready.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      // NOTE: the async clear is what drops PSEL/PENABLE mid-transfer without waiting for a clock edge.
      if (!PRESETn) begin
         r_state     <= ST_IDLE;
         r_cmd_ready <= 1'b1;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so ordering here is irrelevant.
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state     <= ST_SETUP;
                  r_cmd_ready <= 1'b0;
                  r_psel      <= 1'b1;
               end
            end
            ST_SETUP: begin
               r_state   <= ST_ACCESS;
               r_penable <= 1'b1;
            end
            ST_ACCESS: begin
               if (w_done || w_timeout) begin
                  r_state     <= ST_IDLE;
                  r_cmd_ready <= 1'b1;
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cmd_ready <= 1'b1;
               r_psel      <= 1'b0;
               r_penable   <= 1'b0;
            end
         endcase
      end
   end

   // Capture the command on acceptance; the bus fields then hold until the next command.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_paddr  <= '0;
         r_pwrite <= 1'b0;
         r_pstrb  <= '0;
         r_pwdata <= '0;
      end else if (w_accept) begin
         r_paddr  <= cmd_addr;
         r_pwrite <= cmd_write;
         if (cmd_write) begin
            r_pstrb  <= cmd_strb;
            r_pwdata <= cmd_wdata;
         end else begin
            // Reads carry no strobes; the previous write data is left on PWDATA.
            r_pstrb  <= '0;
         end
      end
   end

   // Completion response: one-cycle pulse, data and error held until the next completion.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= w_done || w_timeout;
         if (w_done) begin
            r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
            r_rsp_err   <= PSLVERR;
         end else if (w_timeout) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
         end
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign PSEL      = r_psel;
   assign PENABLE   = r_penable;
   assign PADDR     = r_paddr;
   assign PWRITE    = r_pwrite;
   assign PSTRB     = r_pstrb;
   assign PWDATA    = r_pwdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-outstanding APB master that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers. It sits directly upstream of `apb_gpio` and any other APB slave on the peripheral bus, driving their `PSEL`/`PENABLE`/`PADDR`/`PWRITE`/`PSTRB`/`PWDATA`. It returns read data and error status as a one-cycle response pulse. An optional wait-state watchdog terminates hung transfers.

## Interface
Clock and reset: one clock, `PCLK`. Reset `PRESETn` is asynchronous and active-low.

Parameters:
- `PDATA_SIZE`, 32, data width; must be a multiple of 8.
- `PADDR_SIZE`, 4, address width.
- `TIMEOUT_CYCLES`, 16, maximum ACCESS cycles with `PREADY` low before abort; used only with `APB_BRIDGE_TIMEOUT_EN`; range 1..255.

Ports:
- `PCLK` in 1 — bus clock.
- `PRESETn` in 1 — asynchronous active-low reset.
- `cmd_valid` in 1 — command request.
- `cmd_ready` out 1 — bridge can accept a command.
- `cmd_write` in 1 — 1 = write, 0 = read.
- `cmd_addr` in `PADDR_SIZE` — target address.
- `cmd_strb` in `PDATA_SIZE/8` — write byte strobes.
- `cmd_wdata` in `PDATA_SIZE` — write data.
- `rsp_valid` out 1 — one-cycle completion pulse.
- `rsp_rdata` out `PDATA_SIZE` — read data; 0 for writes and timeouts.
- `rsp_err` out 1 — `PSLVERR` sampled at completion, or timeout.
- `PSEL` out 1 — APB select.
- `PENABLE` out 1 — APB enable.
- `PADDR` out `PADDR_SIZE` — APB address.
- `PWRITE` out 1 — APB direction.
- `PSTRB` out `PDATA_SIZE/8` — APB strobes.
- `PWDATA` out `PDATA_SIZE` — APB write data.
- `PRDATA` in `PDATA_SIZE` — slave read data.
- `PREADY` in 1 — slave ready.
- `PSLVERR` in 1 — slave error.

## Operation
- The FSM has three states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - `cmd_ready`=1.
  - On a `PCLK` edge with `cmd_valid`=1, latch `cmd_*` into `PADDR`/`PWRITE`/`PWDATA`/`PSTRB` and go to SETUP.
  - For reads, `PSTRB` is forced to 0 and `PWDATA` is left unchanged.
- SETUP: `PSEL`=1, `PENABLE`=0, `cmd_ready`=0. Always lasts exactly one cycle, then go to ACCESS.
- ACCESS: `PSEL`=1, `PENABLE`=1.
  - On an edge with `PREADY`=1: capture `rsp_rdata` (`PRDATA` if read, else 0) and `rsp_err`=`PSLVERR`, assert `rsp_valid`, drop `PSEL`/`PENABLE`, go to IDLE.
  - While `PREADY`=0, remain in ACCESS.
- `PADDR`, `PWRITE`, `PWDATA` and `PSTRB` are stable from SETUP through the last ACCESS cycle. They keep their last values in IDLE.
- `rsp_rdata` and `rsp_err` hold their values until the next completion. `rsp_valid` is high for exactly one cycle and there is no backpressure on the response.
- `cmd_valid` seen outside IDLE is ignored; the requester must hold it until it sees `cmd_ready`.
- Reset values: `PSEL`, `PENABLE`, `PWRITE`, `PADDR`, `PSTRB`, `PWDATA`, `rsp_valid`, `rsp_rdata`, `rsp_err` = 0. `cmd_ready`=1. State = IDLE. Wait counter = 0.
- Reset mid-transfer: `PSEL`/`PENABLE` drop immediately (asynchronous) and no `rsp_valid` is generated for the aborted command.

## Timing
- Minimum transfer time is 3 cycles: accept edge (IDLE), then SETUP cycle, then ACCESS cycle with `PREADY`=1.
- `rsp_valid` rises in the cycle after the completing ACCESS edge, concurrently with `cmd_ready`=1. A new command may be accepted in that same cycle.
- Back-to-back throughput: one transfer per 3 cycles with zero wait states. Each wait state adds 1 cycle.
- `PENABLE` never rises without `PSEL` having been high for the preceding cycle.

## Configuration
- Macro: `APB_BRIDGE_TIMEOUT_EN`.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments on each ACCESS edge with `PREADY`=0.
  - When the counter equals `TIMEOUT_CYCLES` and `PREADY`=0, the transfer terminates: go to IDLE, `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0.
  - `PREADY`=1 on that same edge wins: normal completion.
- Undefined: no counter logic; ACCESS waits indefinitely for `PREADY`.

## Test plan
- Write, zero wait: `cmd_write`=1, addr 4'h2, wdata 30, strb 4'hF, `PREADY` tied 1.
  - Expect: SETUP on cycle 1 (`PSEL`=1, `PENABLE`=0), ACCESS on cycle 2, `rsp_valid` on cycle 3 with `rsp_err`=0 and `rsp_rdata`=0.
  - `PADDR`=2, `PWDATA`=30 and `PSTRB`=F stable throughout.
- Read, 2 wait states: addr 4'h0, `PREADY` low for 2 ACCESS cycles, `PRDATA`=32'hA5A5_0003.
  - Expect: ACCESS lasts 3 cycles, `PSTRB`=0, `rsp_rdata`=32'hA5A5_0003, `rsp_valid` on cycle 5.
- Slave error: write with `PSLVERR`=1 during the ready cycle.
  - Expect: `rsp_err`=1. The next clean read returns `rsp_err`=0.
- Timeout (macro defined, `TIMEOUT_CYCLES`=16): `PREADY` stuck 0.
  - Expect: `PSEL` drops after 17 ACCESS cycles, `rsp_err`=1, `rsp_rdata`=0, `cmd_ready`=1.
  - With the macro undefined, still in ACCESS after 100 cycles.
- Back-to-back: `cmd_valid` held high for 4 writes with `PREADY`=1.
  - Expect: 4 `rsp_valid` pulses spaced 3 cycles apart, `PADDR` following each command.
- Reset mid-ACCESS: assert `PRESETn`=0 with `PREADY`=0.
  - Expect: `PSEL`/`PENABLE` low immediately, no `rsp_valid`, `cmd_ready`=1 after release.
